// File: rtl/eth_rx_frame_arbiter.sv
// Frame-atomic round-robin drain of NUM_QUEUES RX frame FIFOs onto one 512b AXIS.
// ETH_RX_ARB_STATS_EN adds per-queue frame counters and an underrun counter.
`default_nettype none

module eth_rx_frame_arbiter #(
  parameter  int NUM_QUEUES = 4,
  localparam int QID_W      = $clog2(NUM_QUEUES)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_QUEUES-1:0]     cfg_queue_en,
  input  logic [NUM_QUEUES-1:0]     fq_empty,
  output logic [NUM_QUEUES-1:0]     fq_read,
  input  logic [NUM_QUEUES*577-1:0] fq_dout,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [511:0]              m_tdata,
  output logic [63:0]               m_tkeep,
  output logic                      m_tlast,
  output logic [QID_W-1:0]          m_tdest,
`ifdef ETH_RX_ARB_STATS_EN
  output logic [NUM_QUEUES*32-1:0]  frame_cnt,
  output logic [31:0]               underrun_cnt,
`endif
  output logic                      busy
);

  localparam logic [QID_W-1:0] LAST_Q = QID_W'(NUM_QUEUES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT
  } state_t;

  state_t           state_q;
  logic [QID_W-1:0] grant_q;
  logic [QID_W-1:0] rr_q;
  logic             tvalid_q;
  logic             busy_q;

  logic [576:0]          word [NUM_QUEUES];
  logic [576:0]          cur;
  logic [NUM_QUEUES-1:0] elig;
  logic [QID_W-1:0]      sel;
  logic [QID_W-1:0]      idx;
  logic                  found;
  logic                  hs;
  logic                  last;
  logic                  gempty;
  logic                  rd_en;
  logic [QID_W-1:0]      rd_q;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_word
    assign word[i] = fq_dout[577*i +: 577];
  end

  assign cur    = word[grant_q];
  assign elig   = cfg_queue_en & ~fq_empty;
  assign hs     = tvalid_q & m_tready;
  assign last   = cur[576];
  assign gempty = fq_empty[grant_q];

  // Walk downward so the candidate closest to rr_q is the last one written.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      idx = QID_W'((int'(rr_q) + k) % NUM_QUEUES);
      if (elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    rd_en = 1'b0;
    rd_q  = grant_q;
    unique case (state_q)
      IDLE: begin
        rd_en = found;
        rd_q  = sel;
      end
      DATA:    rd_en = hs & ~last & ~gempty;
      WAIT:    rd_en = ~gempty;
      default: rd_en = 1'b0;
    endcase
  end

  always_comb begin
    fq_read = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      fq_read[i] = rstn & rd_en & (rd_q == QID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q  <= sel;
            state_q  <= DATA;
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        DATA: begin
          if (hs) begin
            if (last) begin
              rr_q     <= (grant_q == LAST_Q) ? '0 : grant_q + 1'b1;
              state_q  <= IDLE;
              tvalid_q <= 1'b0;
              busy_q   <= 1'b0;
            end else if (gempty) begin
              state_q  <= WAIT;
              tvalid_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (!gempty) begin
            state_q  <= DATA;
            tvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          tvalid_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign m_tvalid = tvalid_q;
  assign busy     = busy_q;
  assign m_tdata  = cur[511:0];
  assign m_tkeep  = cur[575:512];
  assign m_tlast  = cur[576];
  assign m_tdest  = grant_q;

`ifdef ETH_RX_ARB_STATS_EN
  logic [31:0] fcnt_q [NUM_QUEUES];
  logic [31:0] ucnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        fcnt_q[i] <= '0;
      end
      ucnt_q <= '0;
    end else begin
      if (hs && last) begin
        fcnt_q[grant_q] <= fcnt_q[grant_q] + 32'd1;
      end
      if (hs && !last && gempty) begin
        ucnt_q <= ucnt_q + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_fcnt
    assign frame_cnt[32*i +: 32] = fcnt_q[i];
  end
  assign underrun_cnt = ucnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/eth_rx_frame_arbiter.md
Name: eth_rx_frame_arbiter

Overview:
Frame-atomic round-robin scheduler that drains NUM_QUEUES per-cluster RX frame queues onto a single 512-bit AXI-Stream master. It sits between the per-cluster RX frame FIFOs and the host-side DMA stream. It reads standard (non-FWFT) FIFOs: dout is valid the cycle after read. Each queue has a software enable mask, and the output is tagged with the source queue index.

Parameters:
NUM_QUEUES, 4, number of frame queues (2..16)
QID_W, $clog2(NUM_QUEUES) (localparam), width of queue index

Ports:
clk  in  1  clock
rstn  in  1  reset
cfg_queue_en  in  NUM_QUEUES  per-queue arbitration enable
fq_empty  in  NUM_QUEUES  queue empty flags
fq_read  out  NUM_QUEUES  queue read strobes (one-hot or zero)
fq_dout  in  NUM_QUEUES*577  packed queue words {tlast, tkeep[63:0], tdata[511:0]}; queue i at [577*i +: 577]
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tdata  out  512  fq_dout[grant][511:0]
m_tkeep  out  64  fq_dout[grant][575:512]
m_tlast  out  1  fq_dout[grant][576]
m_tdest  out  QID_W  grant (source queue index)
busy  out  1  1 while state != IDLE

Behaviour:
- Reset is rstn, synchronous, active-low, on clock clk. Reset values: state=IDLE, grant=0, rr_ptr=0, fq_read=0, m_tvalid=0, busy=0.
- m_tdata, m_tkeep, m_tlast and m_tdest are combinational from the registered grant. They are don't-care while m_tvalid=0.
- Eligible(i) = cfg_queue_en[i] && !fq_empty[i].
- IDLE:
  - Pick the first eligible queue searching from rr_ptr upward, modulo NUM_QUEUES.
  - If one is found: drive fq_read[sel]=1 the same cycle, grant<=sel, go to DATA.
  - If none is found: stay in IDLE.
  - Latency: one word enters the queue, and m_tvalid rises on the next cycle.
- DATA: m_tvalid=1.
  - Handshake m_tready && !m_tlast: if !fq_empty[grant], fq_read[grant]=1 and stay in DATA; else go to WAIT with no read.
  - Handshake m_tready && m_tlast: no read, rr_ptr<=grant+1 (wrapping to 0 past NUM_QUEUES-1), go to IDLE.
  - No handshake: hold, no read, outputs stable (AXIS rule).
- WAIT: mid-frame underrun; m_tvalid=0. When !fq_empty[grant]: fq_read[grant]=1, go to DATA.
- A frame is never interleaved. The grant changes only in IDLE.
- Clearing cfg_queue_en[grant] mid-frame does not abort the frame. It takes effect at the next IDLE decision.
- Back-to-back frames from different queues: one IDLE bubble cycle between the tlast beat and the next frame's first beat. Sustained throughput per beat inside a frame is 1 word/cycle.
- Single eligible queue: rr_ptr advances past it, and the search wraps back to it, so it is still served every frame.
- Reset mid-frame: state returns to IDLE immediately and the remaining words are abandoned. Queues share rstn and are flushed by their own reset.
- fq_read is never asserted on an empty queue, and never on more than one queue.

Optional Feature:
Macro ETH_RX_ARB_STATS_EN.
- Defined: adds output port frame_cnt of NUM_QUEUES*32 bits. The 32-bit counter for queue i increments by 1 on each m_tvalid&&m_tready&&m_tlast while grant==i. Counters wrap at 2^32-1 to 0 and reset to 0.
- Also adds output underrun_cnt of 32 bits, incrementing on each DATA->WAIT transition.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
1. Queue 0 holds a 3-beat frame, cfg_queue_en=4'hF, m_tready=1 -> fq_read[0] pulses 3 times; 3 beats appear on cycles 2..4 with m_tdest=0 and m_tlast only on the 3rd beat; rr_ptr=1; busy returns to 0.
2. Queues 1 and 3 each hold two 2-beat frames -> frame order q1,q3,q1,q3, with one idle cycle between frames and no interleaving of beats.
3. m_tready toggles 1,0,0,1 during a 4-beat frame -> data is held stable while stalled, no fq_read during stalls, all 4 beats delivered in order.
4. Queue 2 goes empty after beat 1 of 3 for 5 cycles -> m_tvalid=0 for those cycles (WAIT state), resumes with beat 2; with the macro defined, underrun_cnt=1.
5. cfg_queue_en=4'b1101 with queues 1 and 2 non-empty -> only queue 2 is served. Clearing bit 2 mid-frame still completes that frame, then the arbiter idles.
6. Assert rstn=0 during beat 2 of a frame -> next cycle m_tvalid=0, fq_read=0, busy=0, grant=0. With the macro defined, frame_cnt reads 0.
